// File: rtl/ao_exp_arb_if.sv
`default_nettype none
// ============================================================================
// ao_exp_arb_if : requester/expander bundle for the AND-OR expander arbiter
// Rev 1.0 - initial release
// ============================================================================
interface ao_exp_arb_if;
  logic [3:0]  req;
  logic [35:0] ops;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        res;
  logic        busy;
  logic [8:0]  exp_in;
  logic        exp_y;

  modport slave (
    input  req, ops, exp_y,
    output gnt, done, res, busy, exp_in
  );

  modport master (
    output req, ops, exp_y,
    input  gnt, done, res, busy, exp_in
  );
endinterface
`default_nettype wire

// File: rtl/ao_exp_arb.sv
`default_nettype none
// ============================================================================
// ao_exp_arb : 4-way arbiter sharing one AND-OR expander (IDLE/SETTLE/DONE).
// Define AO_EXP_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
// Rev 1.0 - initial release
// ============================================================================
module ao_exp_arb #(
  parameter int SETTLE_CYC = 1
) (
  input  logic         clk,
  input  logic         rst,
  ao_exp_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [3:0]  done_q, done_d;
  logic        res_q, res_d;
  logic        busy_q, busy_d;
  logic [8:0]  exp_in_q, exp_in_d;
  logic [1:0]  win;
  logic [8:0]  win_ops;

`ifdef AO_EXP_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] last_q, last_d;
  logic [1:0] cand;
  logic       found;

  // Search begins one past the previous winner; i==4 wraps back to it.
  always_comb begin
    win   = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + i[1:0];
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    case (win)
      2'd0:    win_ops = bus.ops[8:0];
      2'd1:    win_ops = bus.ops[17:9];
      2'd2:    win_ops = bus.ops[26:18];
      default: win_ops = bus.ops[35:27];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    res_d    = res_q;
    exp_in_d = exp_in_q;
`ifndef AO_EXP_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d    = 4'b0001 << win;
          exp_in_d = win_ops;
          cnt_d    = 4'(SETTLE_CYC);
          state_d  = SETTLE;
`ifndef AO_EXP_ARB_FIXED_PRIO_EN
          last_d   = win;
`endif
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        // Last settle edge: expander output has had SETTLE_CYC cycles to resolve.
        if (cnt_q == 4'd1) begin
          res_d   = bus.exp_y;
          done_d  = gnt_q;
          gnt_d   = 4'b0000;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      gnt_q    <= 4'b0000;
      done_q   <= 4'b0000;
      res_q    <= 1'b0;
      busy_q   <= 1'b0;
      exp_in_q <= 9'd0;
`ifndef AO_EXP_ARB_FIXED_PRIO_EN
      last_q   <= 2'd3;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      exp_in_q <= exp_in_d;
`ifndef AO_EXP_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.res    = res_q;
  assign bus.busy   = busy_q;
  assign bus.exp_in = exp_in_q;

endmodule
`default_nettype wire
